// File: rtl/capture_readout_if.sv
// Valid/ready sample stream from the capture readout engine to the host bridge.
interface capture_readout_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/capture_readout.sv
// Reads a trigger-centred window out of the capture circular RAM and streams it out,
// absorbing the 1-cycle RAM latency and downstream backpressure with a 2-slot FIFO.
module capture_readout #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              capture_enabled,
    input  logic [ADDR_W-1:0] addr_trig,
    input  logic [ADDR_W-1:0] pnts_before_trig,
    input  logic [ADDR_W:0]   n_pnts,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    capture_readout_if.master m,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT_CAP, READ} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_N = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic              cap_meta, cap_s;
    logic [ADDR_W:0]   n_lat, issue_cnt;
    logic [ADDR_W-1:0] pre_lat;
    logic              rd_inflight, rd_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt, occ;
    logic              start_bad, start_ok, pop, final_pop, issue, issue_last;
    logic              err_nx, done_nx, base_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_meta <= 1'b0;
            cap_s    <= 1'b0;
        end else begin
            cap_meta <= capture_enabled;
            cap_s    <= cap_meta;
        end
    end

    // Stream side is a plain view of the FIFO head.
    always_comb begin
        m.m_data  = fifo_data[rd_ptr];
        m.m_valid = (fifo_cnt != 2'd0);
        m.m_last  = m.m_valid && fifo_last[rd_ptr];
    end

    // A FIFO slot is reserved at issue time, so in-flight reads count toward occupancy;
    // a same-cycle pop frees a slot, which keeps one read per cycle under full throughput.
    always_comb begin
        pop        = m.m_valid && m.m_ready;
        final_pop  = pop && m.m_last;
        occ        = fifo_cnt + 2'(rd_inflight);
        issue      = (state == READ) && (issue_cnt != n_lat) && ((occ != 2'd2) || pop);
        issue_last = issue && (issue_cnt == n_lat - ONE_N);
        start_bad  = (n_pnts == '0) || (n_pnts > DEPTH);
    end

    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        err_nx    = 1'b0;
        done_nx   = 1'b0;
        base_load = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        err_nx = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = WAIT_CAP;
                    end
                end
            end
            WAIT_CAP: begin
                if (!cap_s) begin
                    base_load = 1'b1;
                    state_nx  = READ;
                end
            end
            READ: begin
                if (final_pop) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat        <= '0;
            pre_lat      <= '0;
            issue_cnt    <= '0;
            ram_addr     <= '0;
            rd_inflight  <= 1'b0;
            rd_last      <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= '0;
        end else begin
            if (start_ok) begin
                n_lat   <= n_pnts;
                pre_lat <= pnts_before_trig;
            end
            if (base_load) begin
                ram_addr  <= addr_trig - pre_lat;
                issue_cnt <= '0;
            end else if (issue) begin
                ram_addr  <= ram_addr + ADDR_W'(1);
                issue_cnt <= issue_cnt + ONE_N;
            end
            rd_inflight <= issue;
            rd_last     <= issue_last;
            if (rd_inflight) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= rd_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(rd_inflight) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout: a RAM model with a unique word per address lets
// every streamed beat identify the address it was read from.
`timescale 1ns/1ps
module tb_capture_readout;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              capture_enabled = 1'b0;
    logic [ADDR_W-1:0] addr_trig = '0;
    logic [ADDR_W-1:0] pnts_before_trig = '0;
    logic [ADDR_W:0]   n_pnts = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout = '0;
    logic              busy, done, err;
    logic [DATA_W-1:0] mem [4096];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    capture_readout_if #(.DATA_W(DATA_W)) s_if ();

    capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .capture_enabled(capture_enabled),
        .addr_trig(addr_trig), .pnts_before_trig(pnts_before_trig), .n_pnts(n_pnts),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .m(s_if.master),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    function automatic logic [DATA_W-1:0] pat(input int unsigned a);
        return DATA_W'(((a % 4096) * 5 + 3) ^ 32'h1555);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic kick(input int unsigned trig, input int unsigned pre, input int unsigned n);
        @(negedge clk);
        addr_trig        = ADDR_W'(trig);
        pnts_before_trig = ADDR_W'(pre);
        n_pnts           = (ADDR_W+1)'(n);
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects a record; stop_at <= n aborts after that many beats (no end-of-record checks).
    task automatic run_record(input int unsigned base, input int unsigned n, input bit bp,
                              input int unsigned stop_at, output int unsigned first_valid);
        int unsigned beat = 0;
        int unsigned cyc = 0;
        int unsigned occ_max = 0;
        int unsigned occ;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] held_d = '0;
        logic held_l = 1'b0;
        first_valid = 0;
        while (beat < n && beat != stop_at && cyc < n * 4 + 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) pnts_before_trig = pnts_before_trig + ADDR_W'(7);
            if (cyc == 2) begin
                n_pnts = 13'd3;
                start  = 1'b1;
            end
            if (cyc == 3) begin
                start     = 1'b0;
                addr_trig = addr_trig + ADDR_W'(1234);
            end
            if (stalled) begin
                chk("stall_valid", 32'(s_if.m_valid), 32'd1);
                chk("stall_data", 32'(s_if.m_data), 32'(held_d));
                chk("stall_last", 32'(s_if.m_last), 32'(held_l));
            end
            if (bp) s_if.m_ready = !((cyc >= 3 && cyc <= 8) || (cyc > 8 && cyc % 2 == 1));
            else    s_if.m_ready = 1'b1;
            occ = int'(dut.fifo_cnt) + int'(dut.rd_inflight);
            if (occ > occ_max) occ_max = occ;
            if (s_if.m_valid && first_valid == 0) first_valid = cyc;
            if (s_if.m_valid && s_if.m_ready) begin
                chk("beat_data", 32'(s_if.m_data), 32'(pat(base + beat)));
                chk("beat_last", 32'(s_if.m_last), 32'(beat == n - 1));
                beat++;
            end
            stalled = s_if.m_valid && !s_if.m_ready;
            held_d  = s_if.m_data;
            held_l  = s_if.m_last;
        end
        chk("occ_le_2", 32'(occ_max <= 2), 32'd1);
        chk("beats", beat, (stop_at < n) ? stop_at : n);
        if (stop_at > n) begin
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_end", 32'(busy), 32'd0);
            chk("valid_end", 32'(s_if.m_valid), 32'd0);
            @(negedge clk);
            chk("done_once", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned fv;
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);
        s_if.m_ready = 1'b1;
        #12;
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_valid", 32'(s_if.m_valid), 32'd0);
        chk("rst_data", 32'(s_if.m_data), 32'd0);
        chk("rst_last", 32'(s_if.m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        kick(100, 10, 20);
        run_record(90, 20, 1'b0, 21, fv);
        chk("first_valid_lat", 32'(fv > 0 && fv <= 4), 32'd1);
        chk("ram_addr_end", 32'(ram_addr), 32'd110);

        kick(5, 10, 20);
        run_record(4091, 20, 1'b0, 21, fv);

        kick(200, 0, 16);
        run_record(200, 16, 1'b1, 17, fv);

        capture_enabled = 1'b1;
        repeat (3) @(negedge clk);
        kick(300, 20, 8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 40) addr_trig = ADDR_W'(320);
            chk("wait_valid", 32'(s_if.m_valid), 32'd0);
            chk("wait_addr", 32'(ram_addr), 32'd216);
            chk("wait_busy", 32'(busy), 32'd1);
        end
        capture_enabled = 1'b0;
        run_record(300, 8, 1'b0, 9, fv);
        chk("cap_latency", 32'(fv > 0 && fv <= 5), 32'd1);

        kick(10, 0, 0);
        chk("err_n0", 32'(err), 32'd1);
        chk("busy_n0", 32'(busy), 32'd0);
        chk("valid_n0", 32'(s_if.m_valid), 32'd0);
        @(negedge clk);
        chk("err_n0_once", 32'(err), 32'd0);
        chk("busy_n0_after", 32'(busy), 32'd0);

        kick(10, 0, 4097);
        chk("err_big", 32'(err), 32'd1);
        chk("busy_big", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_big_once", 32'(err), 32'd0);

        kick(7, 0, 4096);
        run_record(7, 4096, 1'b0, 4097, fv);

        kick(500, 3, 20);
        run_record(497, 20, 1'b0, 5, fv);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_valid", 32'(s_if.m_valid), 32'd0);
        chk("mid_rst_data", 32'(s_if.m_data), 32'd0);
        chk("mid_rst_last", 32'(s_if.m_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kick(500, 3, 20);
        run_record(497, 20, 1'b0, 21, fv);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Downstream consumer of the trigger-capture circular RAM. Drives its read port and streams the captured record out over a valid/ready interface to the host/AXI bridge.
- After capture stops, it reads a window starting pnts_before_trig samples before the latched trigger address and emits n_pnts samples in order.
- Handles the 1-cycle RAM read latency and downstream backpressure without losing or duplicating samples.

Parameters:
- ADDR_W, 12, RAM address width; buffer depth is 2^ADDR_W.
- DATA_W, 14, sample width.

Ports:
- clk  in  1  single clock; also drives the RAM read-port clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to read out a record.
- capture_enabled  in  1  RAM "enabled" flag; capture is in progress while high. Asynchronous to clk.
- addr_trig  in  ADDR_W  trigger write address latched by the capture RAM.
- pnts_before_trig  in  ADDR_W  number of pre-trigger samples to include.
- n_pnts  in  ADDR_W+1  total samples to read; legal range 1..2^ADDR_W.
- ram_addr  out  ADDR_W  RAM read address.
- ram_dout  in  DATA_W  RAM read data; valid 1 clk after ram_addr.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final sample of the record.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  one-cycle pulse when start carries illegal parameters.

Behaviour:
- Reset (async, rst_n=0): state IDLE. ram_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, err=0. Internal FIFO empty.
- capture_enabled passes through a 2-flop synchronizer; only the synchronized value cap_s is used.
- State machine IDLE -> WAIT_CAP -> READ -> IDLE.
- IDLE:
  - On start with n_pnts==0 or n_pnts>2^ADDR_W: pulse err the next cycle and stay in IDLE.
  - On a legal start: latch n_pnts and pnts_before_trig, then enter WAIT_CAP.
- WAIT_CAP:
  - Stay while cap_s=1.
  - When cap_s=0: sample addr_trig, compute base = (addr_trig - pnts_before_trig) mod 2^ADDR_W, set ram_addr=base, enter READ.
- READ:
  - One RAM read is issued per cycle while issued-minus-consumed < 2. Reads are tracked by a 2-entry output FIFO whose slots are reserved at issue time.
  - ram_addr increments by 1 per issued read and wraps 2^ADDR_W-1 -> 0.
  - Reads stop after n_pnts have been issued.
- Stream:
  - m_valid is high whenever the FIFO is non-empty. A handshake occurs when m_valid && m_ready.
  - m_data, m_valid and m_last hold stable while m_valid && !m_ready.
  - With m_ready held high, the first m_valid arrives within 3 cycles of entering READ, then 1 sample per cycle with no bubbles.
- End of record:
  - m_last is high exactly on the n_pnts-th sample.
  - On that sample's handshake, enter IDLE; done pulses the next cycle; busy drops with the IDLE entry.
- start is ignored while busy.
- addr_trig and pnts_before_trig changes after latching/sampling have no effect on the current record.
- n_pnts=2^ADDR_W reads the whole buffer exactly once, with no address repeated.
- rst_n asserted mid-operation: immediate return to reset values and FIFO flushed. The next start behaves normally.

Test Plan:
- addr_trig=100, pre=10, n_pnts=20, m_ready=1: ram_addr sweeps 90..109; 20 beats equal RAM contents at 90..109; m_last on beat 20; done 1 cycle later; busy low.
- Wrap: addr_trig=5, pre=10, n_pnts=20: addresses 4091..4095 then 0..14; stream order matches.
- Backpressure: n_pnts=16, m_ready low for cycles 3-8 and alternating thereafter: data stable while stalled; exactly 16 beats; no loss or duplication; FIFO occupancy never exceeds 2.
- capture_enabled high at start and low after 50 cycles: no ram reads and m_valid=0 during the wait; readout starts within 3 cycles of the synchronized fall, using addr_trig sampled then.
- n_pnts=0 -> err pulse, no busy, no m_valid. n_pnts=4096, pre=0, addr_trig=7 -> 4096 beats from 7..4095,0..6.
- rst_n low at beat 5 of a 20-beat read: all outputs 0 asynchronously; a new start afterwards produces a correct full record.
